stream_rr_merge: RTL and testbench

//  Parametrised N-to-1 merger for stb/ack streams between generated components and one shared top-level output.

---
 rtl/stream_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/stream_rr_merge.sv | 134 +++++++++++++
 tb/tb_stream_rr_merge.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream round-robin merger.
//   clog2      : ceiling log2 used to size channel-id fields
//   ARB_RR     : round-robin arbitration mode selector
//   ARB_FIXED  : fixed-priority arbitration mode selector (lowest index wins)
//   out_state_t: occupancy of the single output register
package stream_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter.
//   req      : per-channel request vector
//   ptr      : channel holding highest priority this cycle
//   grant    : one-hot grant (zero when no request)
//   grant_id : binary index of the granted channel (0 when no request)
// A fixed-priority arbiter is obtained by tying ptr to zero.
module rr_arbiter
  import stream_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ID_W   = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [ID_W-1:0]   grant_id
);

  int   idx;
  logic found;

  // Walk channels starting at ptr and wrapping; the first requester wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_rr_merge.sv
// N-to-1 stb/ack stream merger with channel tagging and sticky exception
// collection.
//   clk, rst          : clock and asynchronous active-low reset
//   input_in          : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   input_in_stb/ack  : per-channel handshake; ack is one-hot or zero
//   output_out        : merged data word, held while stb high and ack low
//   output_out_id     : source channel of output_out
//   output_out_stb/ack: merged handshake
//   exception_in      : per-channel exception levels
//   exception_clr     : single-cycle clear of the sticky status
//   exception_status  : sticky per-channel exception flags
//   exception_first   : first channel to fault since the last clear
//   exception         : registered OR of exception_status
module stream_rr_merge
  import stream_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 32,
  parameter int ARB_MODE = ARB_RR,
  localparam int ID_W    = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] input_in,
  input  logic [NUM_CH-1:0]       input_in_stb,
  output logic [NUM_CH-1:0]       input_in_ack,
  output logic [WIDTH-1:0]        output_out,
  output logic [ID_W-1:0]         output_out_id,
  output logic                    output_out_stb,
  input  logic                    output_out_ack,
  input  logic [NUM_CH-1:0]       exception_in,
  input  logic                    exception_clr,
  output logic [NUM_CH-1:0]       exception_status,
  output logic [ID_W-1:0]         exception_first,
  output logic                    exception
);

  out_state_t        state, state_next;
  logic              accept;
  logic              xfer;
  logic [NUM_CH-1:0] grant;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   arb_ptr;
  logic [WIDTH-1:0]  data_q;
  logic [ID_W-1:0]   id_q;
  logic [NUM_CH-1:0] status_q;
  logic [NUM_CH-1:0] status_base;
  logic [NUM_CH-1:0] status_next;
  logic [ID_W-1:0]   first_q;
  logic              exc_q;

  function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  // Fixed priority is the rotating arbiter pinned at channel 0.
  assign arb_ptr = (ARB_MODE == ARB_FIXED) ? '0 : ptr;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_arb (
    .req      (input_in_stb),
    .ptr      (arb_ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_EMPTY;
    else      state <= state_next;
  end

  // Acks are suppressed while reset is asserted so no upstream word is
  // consumed by a register that is being held empty.
  always_comb begin
    state_next   = state;
    accept       = (state == ST_EMPTY) || output_out_ack;
    xfer         = accept && rst && (|input_in_stb);
    input_in_ack = xfer ? grant : '0;
    if (xfer) begin
      state_next = ST_FULL;
    end else if ((state == ST_FULL) && output_out_ack) begin
      state_next = ST_EMPTY;
    end
  end

  // Output register and rotating pointer; pointer moves only on a transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      id_q   <= '0;
      ptr    <= '0;
    end else if (xfer) begin
      data_q <= input_in[grant_id*WIDTH +: WIDTH];
      id_q   <= grant_id;
      ptr    <= (grant_id == ID_W'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // A bit whose input is high this cycle survives the clear.
  assign status_base = exception_clr ? '0 : status_q;
  assign status_next = status_base | exception_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= '0;
      first_q  <= '0;
      exc_q    <= 1'b0;
    end else begin
      status_q <= status_next;
      exc_q    <= |status_q;
      if ((status_base == '0) && (|exception_in)) begin
        first_q <= lowest_set(exception_in);
      end else if (exception_clr) begin
        first_q <= '0;
      end
    end
  end

  assign output_out       = data_q;
  assign output_out_id    = id_q;
  assign output_out_stb   = (state == ST_FULL);
  assign exception_status = status_q;
  assign exception_first  = first_q;
  assign exception        = exc_q;

endmodule

// File: tb/tb_stream_rr_merge.sv
module tb_stream_rr_merge;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 32;
  localparam int ID_W   = 2;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH*WIDTH-1:0] input_in;
  logic [NUM_CH-1:0]       input_in_stb;
  logic                    output_out_ack;
  logic [NUM_CH-1:0]       exception_in;
  logic                    exception_clr;

  logic [NUM_CH-1:0]       rr_in_ack;
  logic [WIDTH-1:0]        rr_out;
  logic [ID_W-1:0]         rr_out_id;
  logic                    rr_out_stb;
  logic [NUM_CH-1:0]       rr_status;
  logic [ID_W-1:0]         rr_first;
  logic                    rr_exc;

  logic [NUM_CH-1:0]       fp_in_ack;
  logic [WIDTH-1:0]        fp_out;
  logic [ID_W-1:0]         fp_out_id;
  logic                    fp_out_stb;
  logic [NUM_CH-1:0]       fp_status;
  logic [ID_W-1:0]         fp_first;
  logic                    fp_exc;

  int n_assert = 0;
  int n_fail   = 0;

  stream_rr_merge #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .ARB_MODE(0)) dut (
    .clk              (clk),
    .rst              (rst),
    .input_in         (input_in),
    .input_in_stb     (input_in_stb),
    .input_in_ack     (rr_in_ack),
    .output_out       (rr_out),
    .output_out_id    (rr_out_id),
    .output_out_stb   (rr_out_stb),
    .output_out_ack   (output_out_ack),
    .exception_in     (exception_in),
    .exception_clr    (exception_clr),
    .exception_status (rr_status),
    .exception_first  (rr_first),
    .exception        (rr_exc)
  );

  stream_rr_merge #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .ARB_MODE(1)) dut_fp (
    .clk              (clk),
    .rst              (rst),
    .input_in         (input_in),
    .input_in_stb     (input_in_stb),
    .input_in_ack     (fp_in_ack),
    .output_out       (fp_out),
    .output_out_id    (fp_out_id),
    .output_out_stb   (fp_out_stb),
    .output_out_ack   (output_out_ack),
    .exception_in     (exception_in),
    .exception_clr    (exception_clr),
    .exception_status (fp_status),
    .exception_first  (fp_first),
    .exception        (fp_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] d);
    input_in[ch*WIDTH +: WIDTH] = d;
  endtask

  initial begin
    rst            = 1'b0;
    input_in       = '0;
    input_in_stb   = 4'b1111;
    output_out_ack = 1'b0;
    exception_in   = '0;
    exception_clr  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 32'hD000_0000 | i);

    // Reset held with every channel requesting
    tick(); tick(); tick();
    #1;
    chk("reset_ack_rr", rr_in_ack, 4'b0000);
    chk("reset_ack_fp", fp_in_ack, 4'b0000);
    chk("reset_stb", rr_out_stb, 1'b0);
    chk("reset_out", rr_out, 32'h0);
    chk("reset_status", rr_status, 4'b0000);
    chk("reset_exc", rr_exc, 1'b0);

    // Round-robin fairness with all channels requesting and no backpressure
    rst = 1'b1;
    output_out_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr_grant_%0d", k), rr_in_ack, 4'b0001 << (k % 4));
      chk($sformatf("fp_grant_%0d", k), fp_in_ack, 4'b0001);
      if (k > 0) begin
        chk($sformatf("rr_id_%0d", k), rr_out_id, (k - 1) % 4);
        chk($sformatf("rr_data_%0d", k), rr_out, 32'hD000_0000 | ((k - 1) % 4));
        chk($sformatf("rr_stb_%0d", k), rr_out_stb, 1'b1);
      end
      tick();
    end
    #1;
    chk("rr_id_last", rr_out_id, 2'd0);

    // Backpressure: ch2 word held while the downstream stalls
    input_in_stb = 4'b0100;
    set_ch(2, 32'hA5A5_0001);
    #1;
    chk("bp_load_ack", rr_in_ack, 4'b0100);
    tick();
    output_out_ack = 1'b0;
    set_ch(2, 32'hA5A5_0002);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_data_%0d", k), rr_out, 32'hA5A5_0001);
      chk($sformatf("bp_id_%0d", k), rr_out_id, 2'd2);
      chk($sformatf("bp_stb_%0d", k), rr_out_stb, 1'b1);
      chk($sformatf("bp_ack_%0d", k), rr_in_ack, 4'b0000);
      tick();
    end
    output_out_ack = 1'b1;
    #1;
    chk("bp_release_ack", rr_in_ack, 4'b0100);
    chk("bp_release_data", rr_out, 32'hA5A5_0001);
    tick();
    #1;
    chk("bp_next_data", rr_out, 32'hA5A5_0002);
    chk("bp_next_id", rr_out_id, 2'd2);
    input_in_stb = 4'b0000;
    tick();
    #1;
    chk("bp_drain_stb", rr_out_stb, 1'b0);

    // Fixed priority: ch1 beats ch3 every cycle
    input_in_stb = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("fp_ack_%0d", k), fp_in_ack, 4'b0010);
      tick();
      #1;
      chk($sformatf("fp_id_%0d", k), fp_out_id, 2'd1);
      chk($sformatf("fp_data_%0d", k), fp_out, 32'hD000_0001);
    end
    input_in_stb = 4'b0000;
    tick(); tick();

    // Exceptions: sticky status, first-fault capture, clear semantics
    exception_in = 4'b0100;
    tick();
    #1;
    chk("exc_status_a", rr_status, 4'b0100);
    chk("exc_first_a", rr_first, 2'd2);
    exception_in = 4'b0001;
    tick();
    #1;
    chk("exc_status_b", rr_status, 4'b0101);
    chk("exc_first_b", rr_first, 2'd2);
    exception_in = 4'b0000;
    tick();
    #1;
    chk("exc_flag", rr_exc, 1'b1);
    chk("exc_status_c", rr_status, 4'b0101);
    exception_clr = 1'b1;
    exception_in  = 4'b0001;
    tick();
    #1;
    chk("clr_status", rr_status, 4'b0001);
    chk("clr_first", rr_first, 2'd0);
    exception_in = 4'b0000;
    tick();
    #1;
    chk("clr_all_status", rr_status, 4'b0000);
    chk("clr_all_first", rr_first, 2'd0);
    exception_clr = 1'b0;
    tick(); tick();
    #1;
    chk("exc_flag_low", rr_exc, 1'b0);
    exception_in = 4'b1000;
    tick();
    #1;
    chk("exc3_status", rr_status, 4'b1000);
    chk("exc3_first", rr_first, 2'd3);
    exception_in = 4'b0010;
    tick();
    #1;
    chk("exc31_status", rr_status, 4'b1010);
    chk("exc31_first_hold", rr_first, 2'd3);
    exception_clr = 1'b1;
    tick();
    #1;
    chk("survive_status", rr_status, 4'b0010);
    chk("survive_first", rr_first, 2'd1);
    exception_clr = 1'b0;
    exception_in  = 4'b0000;
    tick(); tick();
    #1;
    chk("exc_flag_pre_rst", rr_exc, 1'b1);

    // Asynchronous reset while the output register is full
    input_in_stb   = 4'b0001;
    output_out_ack = 1'b0;
    tick();
    #1;
    chk("pre_rst_stb", rr_out_stb, 1'b1);
    chk("pre_rst_id", rr_out_id, 2'd0);
    rst = 1'b0;
    #1;
    chk("async_rst_stb", rr_out_stb, 1'b0);
    chk("async_rst_out", rr_out, 32'h0);
    chk("async_rst_status", rr_status, 4'b0000);
    chk("async_rst_exc", rr_exc, 1'b0);
    tick();
    input_in_stb   = 4'b1111;
    output_out_ack = 1'b1;
    rst = 1'b1;
    #1;
    chk("resume_ack0", rr_in_ack, 4'b0001);
    tick();
    #1;
    chk("resume_id0", rr_out_id, 2'd0);
    chk("resume_ack1", rr_in_ack, 4'b0010);
    tick();
    #1;
    chk("resume_id1", rr_out_id, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
